alu_share_ctrl: RTL and testbench

Sequencing and arbitration controller that shares the single 16-bit ALU between two requesters, e.g. the execute stage and an address/compare path. It accepts one operation at a time over valid/ready handshakes and drives the ALU from registered operands. It captures the result and SZCV flags, returns them over a response handshake, and owns the architectural condition-code register.

---
 rtl/alu_share_ctrl_if.sv | 53 +++++
 rtl/alu_share_ctrl.sv | 106 ++++++++++
 tb/tb_alu_share_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_ctrl_if.sv
// Request, ALU-drive and response signals of the shared-ALU controller.
// The slave modport is the controller's view; the master modport is the environment's view.
interface alu_share_ctrl_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [3:0]  req0_op;
    logic [15:0] req0_a;
    logic [15:0] req0_b;
    logic        req0_setcc;

    logic        req1_valid;
    logic        req1_ready;
    logic [3:0]  req1_op;
    logic [15:0] req1_a;
    logic [15:0] req1_b;
    logic        req1_setcc;

    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_op;
    logic [15:0] alu_res;
    logic [3:0]  alu_szcv;

    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [15:0] rsp_res;
    logic [3:0]  rsp_szcv;
    logic        rsp_err;
    logic [3:0]  szcv_q;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, req0_setcc,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b, req1_setcc,
        output req1_ready,
        output alu_a, alu_b, alu_op,
        input  alu_res, alu_szcv,
        output rsp_valid, rsp_id, rsp_res, rsp_szcv, rsp_err, szcv_q,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b, req0_setcc,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b, req1_setcc,
        input  req1_ready,
        input  alu_a, alu_b, alu_op,
        output alu_res, alu_szcv,
        input  rsp_valid, rsp_id, rsp_res, rsp_szcv, rsp_err, szcv_q,
        output rsp_ready
    );
endinterface

// File: rtl/alu_share_ctrl.sv
// Round-robin sharing of one 16-bit ALU between two requesters, with result/flag
// capture, a response handshake and the architectural condition-code register.
module alu_share_ctrl #(
    parameter logic [3:0] FLAG_INIT = 4'b0000
) (
    input  logic           clk,
    input  logic           rst,
    alu_share_ctrl_if.slave bus
);
    localparam int unsigned DW = 16;
    localparam int unsigned OW = 4;
    localparam int unsigned FW = 4;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e          state_q;
    logic            lg_q;
    logic            setcc_q;
    logic            id_q;
    logic [OW-1:0]   op_q;
    logic [DW-1:0]   a_q;
    logic [DW-1:0]   b_q;
    logic            rsp_valid_q;
    logic            rsp_id_q;
    logic            rsp_err_q;
    logic [DW-1:0]   rsp_res_q;
    logic [FW-1:0]   rsp_szcv_q;
    logic [FW-1:0]   cc_q;

    logic            gnt0_c;
    logic            gnt1_c;
    logic            hs_c;
    logic            op_undef_c;

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        gnt0_c     = bus.req0_valid && (!bus.req1_valid || lg_q);
        gnt1_c     = bus.req1_valid && (!bus.req0_valid || !lg_q);
        hs_c       = (state_q == IDLE) && (gnt0_c || gnt1_c);
        op_undef_c = (op_q == 4'b0111) || (op_q[3:2] == 2'b11);
    end

    assign bus.req0_ready = (state_q == IDLE) && gnt0_c;
    assign bus.req1_ready = (state_q == IDLE) && gnt1_c;

    // The operand registers drive the ALU directly, so operands are stable for the whole EXEC cycle.
    assign bus.alu_a     = a_q;
    assign bus.alu_b     = b_q;
    assign bus.alu_op    = op_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_res   = rsp_res_q;
    assign bus.rsp_szcv  = rsp_szcv_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.szcv_q    = cc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lg_q        <= 1'b1;
            setcc_q     <= 1'b0;
            id_q        <= 1'b0;
            op_q        <= OW'(0);
            a_q         <= DW'(0);
            b_q         <= DW'(0);
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_res_q   <= DW'(0);
            rsp_szcv_q  <= FW'(0);
            cc_q        <= FLAG_INIT;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hs_c) begin
                        op_q    <= gnt1_c ? bus.req1_op    : bus.req0_op;
                        a_q     <= gnt1_c ? bus.req1_a     : bus.req0_a;
                        b_q     <= gnt1_c ? bus.req1_b     : bus.req0_b;
                        setcc_q <= gnt1_c ? bus.req1_setcc : bus.req0_setcc;
                        id_q    <= gnt1_c;
                        lg_q    <= gnt1_c;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_res_q   <= bus.alu_res;
                    rsp_szcv_q  <= bus.alu_szcv;
                    rsp_err_q   <= op_undef_c;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    if (setcc_q && !op_undef_c) begin
                        cc_q <= bus.alu_szcv;
                    end
                    state_q <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a behavioural ALU in the environment.
module tb_alu_share_ctrl;
    localparam logic [3:0] FINIT = 4'b0010;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    alu_share_ctrl_if bus();

    alu_share_ctrl #(.FLAG_INIT(FINIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 compare(sub), other defined ops pass a; undefined -> 0.
    function automatic logic [19:0] alu_model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] w;
        logic [15:0] r;
        logic        c;
        logic        v;
        c = 1'b0;
        v = 1'b0;
        case (op)
            4'd0: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[15:0];
                c = w[16];
                v = (a[15] == b[15]) && (r[15] != a[15]);
            end
            4'd1, 4'd5: begin
                r = a - b;
                c = (a < b);
                v = (a[15] != b[15]) && (r[15] != a[15]);
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd7, 4'd12, 4'd13, 4'd14, 4'd15: r = 16'h0000;
            default: r = a;
        endcase
        return {r[15], (r == 16'h0000), c, v, r};
    endfunction

    logic [19:0] alu_out;
    always_comb alu_out = alu_model(bus.alu_op, bus.alu_a, bus.alu_b);
    assign bus.alu_res  = alu_out[15:0];
    assign bus.alu_szcv = alu_out[19:16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic id, input logic v, input logic [3:0] op,
                         input logic [15:0] a, input logic [15:0] b, input logic sc);
        if (id) begin
            bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_setcc = sc;
        end else begin
            bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_setcc = sc;
        end
    endtask

    // Waits (bounded) at negedges for the requester's grant; returns 1 when granted.
    task automatic wait_grant(input logic id, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ((id ? bus.req1_ready : bus.req0_ready) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("grant_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic        id;
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        setcc;
        logic [15:0] res;
        logic [3:0]  szcv;
        logic        err;
        logic [3:0]  q;
    } vec_t;

    vec_t vecs[9];

    task automatic run_vec(input vec_t v);
        logic ok;
        drive(v.id, 1'b1, v.op, v.a, v.b, v.setcc);
        wait_grant(v.id, ok);
        if (!ok) begin
            drive(v.id, 1'b0, 4'd0, 16'd0, 16'd0, 1'b0);
            return;
        end
        chk("other_ready_low", 32'(v.id ? bus.req0_ready : bus.req1_ready), 32'd0);
        @(posedge clk); #1;
        drive(v.id, 1'b0, 4'd0, 16'd0, 16'd0, 1'b0);
        @(negedge clk);
        chk("rsp_valid_exec", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("rsp_res", 32'(bus.rsp_res), 32'(v.res));
        chk("rsp_szcv", 32'(bus.rsp_szcv), 32'(v.szcv));
        chk("rsp_err", 32'(bus.rsp_err), 32'(v.err));
        chk("rsp_id", 32'(bus.rsp_id), 32'(v.id));
        chk("szcv_q", 32'(bus.szcv_q), 32'(v.q));
        @(posedge clk); #1;
    endtask

    int   gcyc[8];
    logic gid[8];
    int   ng;
    logic ok;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.rsp_ready = 1'b1;
        drive(1'b0, 1'b0, 4'd0, 16'd0, 16'd0, 1'b0);
        drive(1'b1, 1'b0, 4'd0, 16'd0, 16'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_szcv_q", 32'(bus.szcv_q), 32'(FINIT));
        chk("reset_alu_a", 32'(bus.alu_a), 32'd0);
        chk("reset_rsp_res", 32'(bus.rsp_res), 32'd0);
        rst = 1'b0;

        vecs[0] = '{1'b0, 4'b0000, 16'h7FFF, 16'h0001, 1'b1, 16'h8000, 4'b1001, 1'b0, 4'b1001};
        vecs[1] = '{1'b0, 4'b0111, 16'h1234, 16'h0001, 1'b1, 16'h0000, 4'b0100, 1'b1, 4'b1001};
        vecs[2] = '{1'b0, 4'b0000, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 4'b0110, 1'b0, 4'b1001};
        vecs[3] = '{1'b1, 4'b0101, 16'h0005, 16'h0005, 1'b1, 16'h0000, 4'b0100, 1'b0, 4'b0100};
        vecs[4] = '{1'b1, 4'b0001, 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 4'b1010, 1'b0, 4'b1010};
        vecs[5] = '{1'b1, 4'b1100, 16'h00FF, 16'h0001, 1'b1, 16'h0000, 4'b0100, 1'b1, 4'b1010};
        vecs[6] = '{1'b0, 4'b0010, 16'hF0F0, 16'h0FF0, 1'b1, 16'h00F0, 4'b0000, 1'b0, 4'b0000};
        vecs[7] = '{1'b1, 4'b1111, 16'hAAAA, 16'h5555, 1'b1, 16'h0000, 4'b0100, 1'b1, 4'b0000};
        vecs[8] = '{1'b0, 4'b0100, 16'hAAAA, 16'h5555, 1'b1, 16'hFFFF, 4'b1000, 1'b0, 4'b1000};
        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Backpressure: response held five cycles while req1 waits.
        bus.rsp_ready = 1'b0;
        drive(1'b0, 1'b1, 4'b0001, 16'h000A, 16'h0003, 1'b0);
        wait_grant(1'b0, ok);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 4'd0, 16'd0, 16'd0, 1'b0);
        drive(1'b1, 1'b1, 4'b0011, 16'h0101, 16'h1010, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_rsp_res", 32'(bus.rsp_res), 32'h0007);
            chk("bp_rsp_szcv", 32'(bus.rsp_szcv), 32'h0);
            chk("bp_rsp_id", 32'(bus.rsp_id), 32'd0);
            chk("bp_readys", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_hs_valid", 32'(bus.rsp_valid), 32'd1);
        @(negedge clk);
        chk("bp_after_valid", 32'(bus.rsp_valid), 32'd0);
        chk("bp_after_ready1", 32'(bus.req1_ready), 32'd1);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 4'd0, 16'd0, 16'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;

        // Contention from reset: both requesters always valid.
        rst = 1'b1;
        drive(1'b0, 1'b1, 4'b0000, 16'h0001, 16'h0001, 1'b0);
        drive(1'b1, 1'b1, 4'b0000, 16'h0002, 16'h0002, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        ng = 0;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            if (bus.req0_ready && bus.req1_ready) chk("both_ready", 32'd1, 32'd0);
            if (bus.rsp_valid && (bus.req0_ready || bus.req1_ready)) chk("ready_in_resp", 32'd1, 32'd0);
            if ((bus.req0_ready || bus.req1_ready) && ng < 8) begin
                gcyc[ng] = c;
                gid[ng]  = bus.req1_ready;
                ng++;
            end
        end
        chk("cont_grants", 32'(ng), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk("cont_order", 32'(gid[k]), 32'(k % 2));
            chk("cont_cycle", 32'(gcyc[k]), 32'(3 * k));
        end
        drive(1'b0, 1'b0, 4'd0, 16'd0, 16'd0, 1'b0);
        drive(1'b1, 1'b0, 4'd0, 16'd0, 16'd0, 1'b0);
        repeat (4) @(posedge clk);
        #1;

        // Reset during EXEC: response dropped, flags restored, req0 wins next tie.
        drive(1'b1, 1'b1, 4'b0000, 16'h7FFF, 16'h0001, 1'b1);
        wait_grant(1'b1, ok);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 4'd0, 16'd0, 16'd0, 1'b0);
        rst = 1'b1;
        #1;
        chk("rst_exec_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_exec_szcv_q", 32'(bus.szcv_q), 32'(FINIT));
        chk("rst_exec_alu_a", 32'(bus.alu_a), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b0, 1'b1, 4'b0000, 16'h0001, 16'h0001, 1'b0);
        drive(1'b1, 1'b1, 4'b0000, 16'h0002, 16'h0002, 1'b0);
        @(negedge clk);
        chk("rst_first_grant0", 32'(bus.req0_ready), 32'd1);
        chk("rst_first_grant1", 32'(bus.req1_ready), 32'd0);
        chk("rst_after_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_after_szcv_q", 32'(bus.szcv_q), 32'(FINIT));
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 4'd0, 16'd0, 16'd0, 1'b0);
        drive(1'b1, 1'b0, 4'd0, 16'd0, 16'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_next_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("rst_next_rsp_res", 32'(bus.rsp_res), 32'h0002);
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
